// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// One fetch in flight over req/ack, one-entry skid for decode stalls, redirect flush/drain.
module if_stage #(
  parameter int unsigned     WORD      = 64,
  parameter int unsigned     INST_SIZE = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INST_SIZE-1:0] imem_rdata,
  output logic [INST_SIZE-1:0] id_inst,
  output logic [WORD-1:0]      id_pc,
  output logic                 id_valid
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [INST_SIZE-1:0] inst;
    logic [WORD-1:0]      pc;
  } fetch_t;

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  fetch_t          skid_q, skid_d;
  fetch_t          id_q, id_d;
  logic            id_valid_q, id_valid_d;

  logic [WORD-1:0] pc_inc;
  logic            ack_live;

  // Sequential increment wraps naturally at 2^WORD.
  assign pc_inc   = pc_q + WORD'(PC_STEP);
  // Strobes arriving with no request outstanding are not responses.
  assign ack_live = imem_ack & req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      skid_q     <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      skid_q     <= skid_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    skid_d     = skid_q;
    id_d       = id_q;
    // Live entry holds under stall; otherwise decode sees a bubble.
    id_valid_d = id_valid_q & stall;

    case (state_q)
      ST_REQ: begin
        if (!req_q) begin
          // First cycle out of reset: launch the initial request.
          req_d = 1'b1;
          if (redirect) begin
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end else begin
            addr_d = pc_q;
          end
        end else if (ack_live) begin
          if (redirect) begin
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end else if (!stall || !id_valid_q) begin
            id_d.inst  = imem_rdata;
            id_d.pc    = addr_q;
            id_valid_d = 1'b1;
            pc_d       = pc_inc;
            addr_d     = pc_inc;
          end else begin
            skid_d.inst = imem_rdata;
            skid_d.pc   = addr_q;
            pc_d        = pc_inc;
            addr_d      = pc_inc;
            req_d       = 1'b0;
            state_d     = ST_HOLD;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else if (!stall) begin
          id_d       = skid_q;
          id_valid_d = 1'b1;
          addr_d     = pc_q;
          req_d      = 1'b1;
          state_d    = ST_REQ;
        end
      end

      ST_DRAIN: begin
        // Request stays up at the stale address until memory answers it.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (ack_live) begin
          addr_d  = redirect ? redirect_pc : pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (redirect) begin
      id_valid_d = 1'b0;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_inst   = id_q.inst;
  assign id_pc     = id_q.pc;
  assign id_valid  = id_valid_q;

endmodule
